// File: rtl/rggen_multi_action_field.sv
// Multi-channel register field block with per-channel software actions, hardware set/clear and a registered bus handshake.
// Optional parity protection is enabled with the RGGEN_FIELD_PARITY_EN macro.
package rggen_rtl_pkg;
  typedef enum logic [1:0] {
    RGGEN_POSTED_WRITE = 2'b01,
    RGGEN_READ         = 2'b10,
    RGGEN_WRITE        = 2'b11
  } rggen_access;

  typedef enum logic [1:0] {
    RGGEN_OKAY         = 2'b00,
    RGGEN_EXOKAY       = 2'b01,
    RGGEN_SLAVE_ERROR  = 2'b10,
    RGGEN_DECODE_ERROR = 2'b11
  } rggen_status;

  typedef enum logic [3:0] {
    RGGEN_WRITE_NONE,
    RGGEN_WRITE_DEFAULT,
    RGGEN_WRITE_0_CLEAR,
    RGGEN_WRITE_1_CLEAR,
    RGGEN_WRITE_CLEAR,
    RGGEN_WRITE_0_SET,
    RGGEN_WRITE_1_SET,
    RGGEN_WRITE_SET,
    RGGEN_WRITE_0_TOGGLE,
    RGGEN_WRITE_1_TOGGLE,
    RGGEN_READ_NONE,
    RGGEN_READ_DEFAULT,
    RGGEN_READ_CLEAR,
    RGGEN_READ_SET
  } rggen_sw_action;
endpackage

module rggen_multi_action_field
  import rggen_rtl_pkg::*;
#(
  parameter int                          CHANNELS      = 4,
  parameter int                          WIDTH         = 8,
  parameter rggen_sw_action              WRITE_ACTION [CHANNELS] = '{default: RGGEN_WRITE_DEFAULT},
  parameter rggen_sw_action              READ_ACTION  [CHANNELS] = '{default: RGGEN_READ_DEFAULT},
  parameter logic [CHANNELS*WIDTH-1:0]   INITIAL_VALUE = '0,
  localparam int                         CHANNEL_WIDTH = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
)(
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_valid,
  output logic                         o_ready,
  input  logic [1:0]                   i_access,
  input  logic [CHANNEL_WIDTH-1:0]     i_channel,
  input  logic [WIDTH-1:0]             i_write_data,
  input  logic [WIDTH-1:0]             i_strobe,
  output logic                         o_resp_valid,
  input  logic                         i_resp_ready,
  output logic [1:0]                   o_status,
  output logic [WIDTH-1:0]             o_read_data,
  input  logic [CHANNELS*WIDTH-1:0]    i_hw_set,
  input  logic [CHANNELS*WIDTH-1:0]    i_hw_clear,
  output logic [CHANNELS*WIDTH-1:0]    o_value,
  output logic [CHANNELS-1:0]          o_parity_error
);
  typedef enum logic {IDLE, RESP} state_e;

  state_e                      state;
  logic [CHANNELS*WIDTH-1:0]   value_q;
  logic [CHANNELS*WIDTH-1:0]   sw_next;
  logic [CHANNELS*WIDTH-1:0]   value_next;
  logic [CHANNELS-1:0]         parity_error;
  logic                        resp_valid_q;
  rggen_status                 status_q;
  logic [WIDTH-1:0]            read_data_q;
  logic                        accept;
  logic                        posted;
  logic                        hit;
  logic                        flagged;
  logic [WIDTH-1:0]            current;
  rggen_sw_action              write_action;
  rggen_sw_action              read_action;
  rggen_status                 req_status;
  logic [WIDTH-1:0]            req_read_data;

  function automatic logic [WIDTH-1:0] write_value(rggen_sw_action a, logic [WIDTH-1:0] v,
                                                   logic [WIDTH-1:0] d, logic [WIDTH-1:0] s);
    case (a)
      RGGEN_WRITE_DEFAULT:  return (v & ~s) | (d & s);
      RGGEN_WRITE_0_CLEAR:  return v & ~(s & ~d);
      RGGEN_WRITE_1_CLEAR:  return v & ~(s & d);
      RGGEN_WRITE_CLEAR:    return v & ~s;
      RGGEN_WRITE_0_SET:    return v | (s & ~d);
      RGGEN_WRITE_1_SET:    return v | (s & d);
      RGGEN_WRITE_SET:      return v | s;
      RGGEN_WRITE_0_TOGGLE: return v ^ (s & ~d);
      RGGEN_WRITE_1_TOGGLE: return v ^ (s & d);
      default:              return v;
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] read_value(rggen_sw_action a, logic [WIDTH-1:0] v);
    case (a)
      RGGEN_READ_CLEAR: return '0;
      RGGEN_READ_SET:   return '1;
      default:          return v;
    endcase
  endfunction

  // Decode the request against the addressed channel; an errored request never touches the field.
  always_comb begin
    sw_next       = value_q;
    req_status    = RGGEN_OKAY;
    req_read_data = '0;
    hit           = 1'b0;
    flagged       = 1'b0;
    current       = '0;
    write_action  = RGGEN_WRITE_NONE;
    read_action   = RGGEN_READ_NONE;
    accept        = i_valid && (state == IDLE);
    posted        = (i_access == RGGEN_POSTED_WRITE);
    for (int c = 0; c < CHANNELS; c++) begin
      if (int'(i_channel) == c) begin
        hit          = 1'b1;
        flagged      = parity_error[c];
        current      = value_q[c*WIDTH +: WIDTH];
        write_action = WRITE_ACTION[c];
        read_action  = READ_ACTION[c];
      end
    end
    if (!hit || (i_access == 2'b00)) begin
      req_status = RGGEN_DECODE_ERROR;
    end else if (flagged) begin
      req_status = RGGEN_SLAVE_ERROR;
    end else if (i_access == RGGEN_READ) begin
      if (read_action == RGGEN_READ_NONE) req_status = RGGEN_SLAVE_ERROR;
      else                                req_read_data = current;
    end else if (write_action == RGGEN_WRITE_NONE) begin
      req_status = RGGEN_SLAVE_ERROR;
    end
    for (int c = 0; c < CHANNELS; c++) begin
      if (accept && (req_status == RGGEN_OKAY) && (int'(i_channel) == c)) begin
        sw_next[c*WIDTH +: WIDTH] = (i_access == RGGEN_READ) ?
          read_value(read_action, current) :
          write_value(write_action, current, i_write_data, i_strobe);
      end
    end
  end

  assign value_next = (sw_next & ~i_hw_clear) | i_hw_set;

  // Field storage plus the IDLE/RESP handshake; response fields hold until the bus takes them.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= IDLE;
      value_q      <= INITIAL_VALUE;
      resp_valid_q <= 1'b0;
      status_q     <= RGGEN_OKAY;
      read_data_q  <= '0;
    end else begin
      value_q <= value_next;
      case (state)
        IDLE: if (accept && !posted) begin
          state        <= RESP;
          resp_valid_q <= 1'b1;
          status_q     <= req_status;
          read_data_q  <= req_read_data;
        end
        RESP: if (i_resp_ready) begin
          state        <= IDLE;
          resp_valid_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RGGEN_FIELD_PARITY_EN
  logic [CHANNELS-1:0] parity_q;

  // Parity tracks every value update; a mismatch latches until reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int c = 0; c < CHANNELS; c++) parity_q[c] <= ^INITIAL_VALUE[c*WIDTH +: WIDTH];
      parity_error <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        parity_q[c]     <= ^value_next[c*WIDTH +: WIDTH];
        parity_error[c] <= parity_error[c] | (parity_q[c] != ^value_q[c*WIDTH +: WIDTH]);
      end
    end
  end
`else
  assign parity_error = '0;
`endif

  assign o_ready        = (state == IDLE);
  assign o_resp_valid   = resp_valid_q;
  assign o_status       = status_q;
  assign o_read_data    = read_data_q;
  assign o_value        = value_q;
  assign o_parity_error = parity_error;
endmodule
